lfsr_rand_gen: RTL and testbench

- Parametrised Galois LFSR pseudo-random source for the game logic, e.g. platform distance and size selection.
- Next generation of the fixed 10-bit shift-register generator: configurable width and tap polynomial, runtime seed load, and all-zero lockup protection.
- Adds a req/valid interface that returns a uniformly distributed value in [0, range) by rejection sampling.
- Sits between the game FSM (requester) and the platform/scene generator.

---
 rtl/lfsr_rand_gen.sv | 159 +++++++++++++++
 tb/tb_lfsr_rand_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_gen.sv
// Galois LFSR random source with bounded req/valid draw by rejection sampling; LFSR_PERIOD_CNT_EN adds wrap/period.
// Latency req accept -> rand_valid = draws+1 (1 for range 0); req/range are ignored while ready is low.
module lfsr_rand_gen #(
  parameter int               WIDTH        = 10,
  parameter logic [WIDTH-1:0] TAPS         = 10'h204,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 10'h001,
  parameter int               OUT_W        = 8,
  parameter int               MAX_TRIES    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  output logic             ready,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] state,
  output logic [2:0]       retry_cnt
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic             wrap,
  output logic [WIDTH-1:0] period
`endif
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

  localparam logic [OUT_W-1:0] ONE_O = OUT_W'(1);

  fsm_t             fsm_q, fsm_d;
  logic [OUT_W-1:0] rng_q, rng_d;
  logic [OUT_W-1:0] msk_q, msk_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [2:0]       tries_q, tries_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic [OUT_W-1:0] cand;
  logic             step;
  logic             last_try;

  // Smallest power of two >= r, minus one: smear the top set bit of r-1 downward.
  function automatic logic [OUT_W-1:0] pow2_mask(input logic [OUT_W-1:0] r);
    logic [OUT_W-1:0] m;
    m = (r == '0) ? '0 : (r - ONE_O);
    for (int i = 1; i < OUT_W; i = i * 2) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  assign lfsr_nxt = (state >> 1) ^ (state[0] ? TAPS : '0);
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign step     = !load && ((fsm_q == IDLE && en) || fsm_q == DRAW);
  assign cand     = state[OUT_W-1:0] & msk_q;
  assign last_try = (tries_q + 3'd1) == 3'(MAX_TRIES);

  always_comb begin
    fsm_d   = fsm_q;
    rng_d   = rng_q;
    msk_d   = msk_q;
    res_d   = res_q;
    tries_d = tries_q;
    cnt_d   = cnt_q;
    if (load) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (req) begin
            rng_d   = range;
            msk_d   = pow2_mask(range);
            tries_d = '0;
            if (range == '0) begin
              res_d = '0;
              cnt_d = '0;
              fsm_d = DONE;
            end else begin
              fsm_d = DRAW;
            end
          end
        end
        DRAW: begin
          tries_d = tries_q + 3'd1;
          if (cand < rng_q) begin
            res_d = cand;
            cnt_d = tries_q + 3'd1;
            fsm_d = DONE;
          end else if (last_try) begin
            // cand <= mask < 2*range, so one subtraction lands in [0, range)
            res_d = cand - rng_q;
            cnt_d = tries_q + 3'd1;
            fsm_d = DONE;
          end
        end
        DONE:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rng_q   <= '0;
      msk_q   <= '0;
      res_q   <= '0;
      tries_q <= '0;
      cnt_q   <= '0;
      state   <= DEFAULT_SEED;
    end else begin
      fsm_q   <= fsm_d;
      rng_q   <= rng_d;
      msk_q   <= msk_d;
      res_q   <= res_d;
      tries_q <= tries_d;
      cnt_q   <= cnt_d;
      if (load) begin
        state <= seed_eff;
      end else if (step) begin
        state <= lfsr_nxt;
      end
    end
  end

  assign ready      = (fsm_q == IDLE);
  assign rand_valid = (fsm_q == DONE);
  assign rand_out   = res_q;
  assign retry_cnt  = cnt_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] seed_ref;
  logic [WIDTH-1:0] step_cnt;

  assign wrap = step && (lfsr_nxt == seed_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_ref <= DEFAULT_SEED;
      step_cnt <= '0;
      period   <= '0;
    end else if (load) begin
      seed_ref <= seed_eff;
      step_cnt <= '0;
    end else if (step) begin
      if (wrap) begin
        period   <= step_cnt + 1'b1;
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_lfsr_rand_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [9:0] seed;
  logic       req;
  logic [7:0] range;
  logic       ready;
  logic       rand_valid;
  logic [7:0] rand_out;
  logic [9:0] state;
  logic [2:0] retry_cnt;
`ifdef LFSR_PERIOD_CNT_EN
  logic       wrap;
  logic [9:0] period;
`endif

  lfsr_rand_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .seed       (seed),
    .req        (req),
    .range      (range),
    .ready      (ready),
    .rand_valid (rand_valid),
    .rand_out   (rand_out),
    .state      (state),
    .retry_cnt  (retry_cnt)
`ifdef LFSR_PERIOD_CNT_EN
    ,
    .wrap       (wrap),
    .period     (period)
`endif
  );

  typedef struct {
    logic [7:0] out;
    logic [2:0] cnt;
    bit         chk_cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rand_valid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && rand_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: rand_out=%0d with nothing expected", rand_out);
        end else begin
          mon_e = sb.pop_front();
          check("rand_out", 32'(rand_out), 32'(mon_e.out));
          if (mon_e.chk_cnt) check("retry_cnt", 32'(retry_cnt), 32'(mon_e.cnt));
          check("valid_cycle", cyc, mon_e.cyc);
          check("ready_low_in_done", 32'(ready), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [9:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
  endtask

  // Issues a request and records expected result and the cycle rand_valid must appear.
  task automatic do_req(input logic [7:0] r, input logic [7:0] exp_out,
                        input logic [2:0] exp_cnt, input bit chk_cnt, input int lat);
    exp_t e;
    req   = 1'b1;
    range = r;
    @(negedge clk);
    #1;
    e.out     = exp_out;
    e.cnt     = exp_cnt;
    e.chk_cnt = chk_cnt;
    e.cyc     = cyc + lat;
    sb.push_back(e);
    tick();
    req   = 1'b0;
    range = 8'hAA;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results still outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    seed  = '0;
    req   = 1'b0;
    range = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'h001);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(rand_valid), 32'd0);
    check("reset_rand_out", 32'(rand_out), 32'd0);
    check("reset_retry", 32'(retry_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Free-run steps
    en = 1'b1;
    tick();
    check("step1", 32'(state), 32'h204);
    tick();
    check("step2", 32'(state), 32'h102);
    en = 1'b0;

    // Load zero seed with en and req also high: no step, req ignored
    en  = 1'b1;
    req = 1'b1;
    range = 8'd5;
    do_load(10'h000);
    en  = 1'b0;
    req = 1'b0;
    check("load_zero_seed", 32'(state), 32'h001);
    check("load_req_ignored", 32'(ready), 32'd1);
    do_load(10'h3FF);
    check("load_3ff", 32'(state), 32'h3FF);

    // Bounded draws: seed, range, expected out, draws, latency
    do_load(10'h001);
    do_req(8'd5, 8'd1, 3'd1, 1'b1, 2);
    drain("r5_first");
    tick();
    do_load(10'h006);           // candidates 6, 3
    do_req(8'd5, 8'd3, 3'd2, 1'b1, 3);
    drain("r5_second");
    tick();
    do_load(10'h007);           // candidates 7, 7, 7, 7 -> fallback 7-5
    do_req(8'd5, 8'd2, 3'd4, 1'b1, 5);
    drain("r5_fallback");
    tick();
    do_load(10'h3FF);           // candidates 255, 251, 249, 248 -> 248-200
    do_req(8'd200, 8'd48, 3'd4, 1'b1, 5);
    drain("r200_fallback");
    tick();
    tick();
    check("rand_out_hold", 32'(rand_out), 32'd48);

    // range 0 then range 1 back-to-back
    do_req(8'd0, 8'd0, 3'd0, 1'b0, 1);
    drain("r0");
    tick();
    do_req(8'd1, 8'd0, 3'd1, 1'b1, 2);
    drain("r1");
    tick();

    // load mid-draw aborts with no valid
    do_load(10'h007);
    req   = 1'b1;
    range = 8'd5;
    tick();
    req = 1'b0;
    tick();
    do_load(10'h0AB);
    check("abort_load_ready", 32'(ready), 32'd1);
    check("abort_load_state", 32'(state), 32'h0AB);
    repeat (6) tick();
    check("abort_load_rand_out", 32'(rand_out), 32'd0);

    // reset mid-draw aborts with no valid
    do_load(10'h007);
    req   = 1'b1;
    range = 8'd5;
    tick();
    req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rst_state", 32'(state), 32'h001);
    check("abort_rst_retry", 32'(retry_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_rst_ready", 32'(ready), 32'd1);
    repeat (6) tick();

`ifdef LFSR_PERIOD_CNT_EN
    begin
      int nw;
      int first;
      nw    = 0;
      first = -1;
      do_load(10'h001);
      en = 1'b1;
      for (int i = 0; i < 2046; i++) begin
        @(negedge clk);
        if (wrap) begin
          nw++;
          if (first < 0) first = i;
        end
      end
      tick();
      en = 1'b0;
      check("wrap_count", nw, 2);
      check("wrap_first", first, 1022);
      check("period", 32'(period), 32'd1023);
    end
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
